dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory (mem, DEPTH 256 x 64b) between NUM_REQ requesters
//  (req 0 = core load/store unit, req 1 = debug/DMA loader).
//  Round-robin grant, one access in flight, registered memory-side signals, 1-cycle memory read latency.
//  Sits between the requesters and the dmem instance.
// PARAMETERS
//  NUM_REQ    2     number of requesters (2..8)
//  ADDR_W     32    byte address width
//  DATA_W     64    data width; accesses are whole 64-bit words
//  MEM_BYTES  2048  legal byte range [0, MEM_BYTES); larger addresses are errors
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   synchronous, active-high
//  req          in   NUM_REQ             access request; held with we/addr/wdata until gnt
//  req_we       in   NUM_REQ             1 = write, 0 = read
//  req_addr     in   NUM_REQ*ADDR_W      byte address per requester
//  req_wdata    in   NUM_REQ*DATA_W      write data per requester
//  gnt          out  NUM_REQ             one-hot 1-cycle pulse: access accepted
//  rvalid       out  NUM_REQ             one-hot 1-cycle pulse: rdata valid for that requester
//  err          out  NUM_REQ             1-cycle pulse with gnt: address out of range, no access made
//  rdata        out  DATA_W              read data, shared bus, qualified by rvalid
//  mem_rd_en    out  1                   to dmem rd_en
//  mem_wr_en    out  1                   to dmem wr_en
//  mem_addr     out  ADDR_W              to dmem byte_addr
//  mem_wdata    out  DATA_W              to dmem wr_data
//  mem_rdata    in   DATA_W              from dmem rd_data; valid 1 cycle after mem_rd_en
//  stat_grants  out  NUM_REQ*32          per-requester grant count (see CONFIGURATION)
//  stat_stalls  out  32                  cycles with a request pending and not granted
// BEHAVIOUR
//  Reset: state=S_IDLE; gnt, rvalid, err, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata, rdata = 0.
//   last_grant = NUM_REQ-1, so requester 0 wins first. Counters = 0.
//  FSM states:
//   S_IDLE:
//    - if |req at cycle N, winner W = first set bit searching from last_grant+1 (mod NUM_REQ).
//    - Register gnt[W]=1 and last_grant=W.
//    - If addr_W >= MEM_BYTES: err[W]=1, no mem enable, stay S_IDLE.
//    - Else: mem_addr=addr_W, mem_wr_en=we_W, mem_rd_en=!we_W, mem_wdata=wdata_W; -> S_BUSY.
//    - All of the above registered outputs are visible in cycle N+1.
//   S_BUSY (cycle N+1): mem enable is high this cycle only. Write -> S_IDLE. Read -> S_RDWAIT.
//   S_RDWAIT (cycle N+2): rdata <= mem_rdata, rvalid[W]=1 in cycle N+3; -> S_IDLE.
//  Timing:
//   - Read latency: req to rvalid = 3 cycles.
//   - Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
//   - S_IDLE re-arbitrates in the same cycle rvalid is high.
//  Handshake:
//   - Requester keeps req and its payload stable until it samples gnt.
//   - It deasserts req in the following cycle, or keeps req high for a back-to-back access with new payload.
//   - Payload changes while req is high and gnt is not yet seen are illegal (assertion).
//  Simultaneous requests: strict rotation; with both always requesting, grants alternate 0,1,0,1.
//  No pending req: outputs idle, last_grant unchanged.
//  Address: only addr[ADDR_W-1:0] compared, unsigned. Low 3 bits passed through unchanged (mem handles alignment).
//  Reset mid-operation (S_BUSY/S_RDWAIT): access abandoned; no rvalid or err emitted; mem enables drop next cycle.
//  Exactly one of gnt/rvalid bits set at a time (one-hot or zero); gnt and rvalid may coincide for different requesters.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//   - stat_grants[i] increments on gnt[i].
//   - stat_stalls increments each cycle with (req & ~gnt) != 0.
//   - All counters 32-bit, saturate at 32'hFFFF_FFFF, clear on reset.
//  Not defined: counters are not built; stat_grants and stat_stalls are tied to 0.
// STRUCTURE
//  ember_pkg:
//   - typedef enum arb_state_t {S_IDLE, S_BUSY, S_RDWAIT}.
//   - Constants DMEM_BYTES=2048 and REQ_CORE=0, REQ_DBG=1.
//  Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req vector, last_grant.
//   - Outputs: one-hot winner, winner index, any.
//  FSM, payload mux and counters stay in dmem_arbiter.
// TESTING
//  1 Single write:
//    - Stimulus: req0 we=1 addr=0x10 wdata=0xDEADBEEF_CAFEF00D at N.
//    - Expected: gnt0 at N+1; mem_wr_en=1 and mem_addr=0x10 at N+1; idle at N+2.
//  2 Read-back:
//    - Stimulus: req0 read addr=0x10 after test 1.
//    - Expected: gnt0 at N+1, mem_rd_en at N+1, rvalid0 at N+3, rdata=0xDEADBEEF_CAFEF00D.
//  3 Contention:
//    - Stimulus: req0 and req1 continuously requesting writes from reset.
//    - Expected: grant order 0,1,0,1; no double grant; stall count increases while each requester waits.
//  4 Out of range:
//    - Stimulus: req1 read addr=0x800.
//    - Expected: gnt1 and err1 at N+1; mem_rd_en stays 0; no rvalid; next request granted at N+1 arbitration.
//  5 Reset mid-read:
//    - Stimulus: assert reset during S_RDWAIT.
//    - Expected: no rvalid; all outputs 0 next cycle; first post-reset grant goes to requester 0.
//  6 Stats (DMEM_ARB_STATS_EN):
//    - Stimulus: 5 grants to req0, 3 to req1.
//    - Expected: stat_grants = {3,5}.
//    - Without the macro: stat_grants and stat_stalls read 0 throughout.

Source files
------------

// File: rtl/ember_pkg.sv
// Shared types and constants for the data-memory arbiter.
package ember_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RDWAIT
  } arb_state_t;

  localparam int DMEM_BYTES = 2048;
  localparam int REQ_CORE   = 0;
  localparam int REQ_DBG    = 1;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set after last_grant_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] win_onehot_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    win_onehot_o = '0;
    win_idx_o    = '0;
    any_o        = 1'b0;
    pos          = '0;
    // Distance 1 is the requester right after the last winner; distance NUM_REQ is the last winner itself.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!any_o && req_i[pos]) begin
        any_o             = 1'b1;
        win_idx_o         = pos;
        win_onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported dmem; one access in flight, registered memory side.
// Optional usage counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import ember_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ*32-1:0]     stat_grants,
  output logic [31:0]               stat_stalls
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  arb_state_t         state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [NUM_REQ-1:0] cur_oh_q;
  logic [NUM_REQ-1:0] gnt_q, rvalid_q, err_q;
  logic               mem_rd_en_q, mem_wr_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q, rdata_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .win_onehot_o (pick_onehot),
    .win_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_oor;

  assign sel_addr  = addr_arr[pick_idx];
  assign sel_wdata = wdata_arr[pick_idx];
  assign sel_we    = req_we[pick_idx];
  assign sel_oor   = (sel_addr >= ADDR_W'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cur_oh_q     <= '0;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      err_q        <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            gnt_q        <= pick_onehot;
            last_grant_q <= pick_idx;
            cur_oh_q     <= pick_onehot;
            if (sel_oor) begin
              err_q <= pick_onehot;
            end else begin
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_wr_en_q <= sel_we;
              mem_rd_en_q <= !sel_we;
              state_q     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          state_q <= mem_wr_en_q ? S_IDLE : S_RDWAIT;
        end
        S_RDWAIT: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= cur_oh_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (gnt_q[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign stat_grants[gi*32 +: 32] = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (|(req & ~gnt_q) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stat_stalls = stall_cnt_q;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

`ifndef SYNTHESIS
  // A requester must hold its payload until it has seen its grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
    a_payload_stable: assert property (@(posedge clk) disable iff (reset)
      (req[gi] && !gnt_q[gi]) |=> (!req[gi] || $stable({req_we[gi], addr_arr[gi], wdata_arr[gi]})));
  end
`endif

endmodule
